// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop sync, shared sample tick, per-channel debounce FSM
// with press/release/auto-repeat pulses. Auto-repeat is built only with BTN_AUTO_REPEAT_EN.
module btn_cond #(
  parameter int NUM_BTN  = 3,
  parameter int TICK_DIV = 50000,
  parameter int DEB_MS   = 20,
  parameter int HOLD_MS  = 600,
  parameter int RPT_MS   = 150
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] i_sw,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_repeat
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_P,
    ST_PRESSED,
    ST_REPEAT,
    ST_DEB_R
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [15:0] DEB_LIM   = 16'(DEB_MS);

  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic        tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tick_cnt_q <= 32'd0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  // Switches idle high, so the synchronizer resets to "released".
  logic [NUM_BTN-1:0] sync1_q, sync2_q, samp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
    end
  end

  assign samp = ~sync2_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      state_t      state_q, state_d;
      logic [15:0] cnt_q, cnt_d, cnt_inc;
      logic        press_q, press_d;
      logic        release_q, release_d;
      logic        level_q, level_d;
`ifdef BTN_AUTO_REPEAT_EN
      localparam logic [15:0] HOLD_LIM = 16'(HOLD_MS);
      localparam logic [15:0] RPT_LIM  = 16'(RPT_MS);
      logic        repeat_q, repeat_d;
`endif

      assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        level_d   = level_q;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        if (tick) begin
          case (state_q)
            ST_IDLE: begin
              if (samp[gi]) begin
                if (DEB_LIM == 16'd1) begin
                  state_d = ST_PRESSED;
                  cnt_d   = 16'd0;
                  press_d = 1'b1;
                  level_d = 1'b1;
                end else begin
                  state_d = ST_DEB_P;
                  cnt_d   = 16'd1;
                end
              end
            end
            ST_DEB_P: begin
              if (!samp[gi]) begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
              end else if (cnt_inc >= DEB_LIM) begin
                state_d = ST_PRESSED;
                cnt_d   = 16'd0;
                press_d = 1'b1;
                level_d = 1'b1;
              end else begin
                cnt_d = cnt_inc;
              end
            end
`ifdef BTN_AUTO_REPEAT_EN
            ST_PRESSED, ST_REPEAT: begin
`else
            ST_PRESSED: begin
`endif
              if (!samp[gi]) begin
                // A one-sample release debounce degenerates to an immediate release.
                if (DEB_LIM == 16'd1) begin
                  state_d   = ST_IDLE;
                  cnt_d     = 16'd0;
                  release_d = 1'b1;
                  level_d   = 1'b0;
                end else begin
                  state_d = ST_DEB_R;
                  cnt_d   = 16'd1;
                end
`ifdef BTN_AUTO_REPEAT_EN
              end else if (cnt_inc >= ((state_q == ST_PRESSED) ? HOLD_LIM : RPT_LIM)) begin
                state_d  = ST_REPEAT;
                cnt_d    = 16'd0;
                repeat_d = 1'b1;
`endif
              end else begin
                cnt_d = cnt_inc;
              end
            end
            ST_DEB_R: begin
              if (samp[gi]) begin
                state_d = ST_PRESSED;
                cnt_d   = 16'd0;
              end else if (cnt_inc >= DEB_LIM) begin
                state_d   = ST_IDLE;
                cnt_d     = 16'd0;
                release_d = 1'b1;
                level_d   = 1'b0;
              end else begin
                cnt_d = cnt_inc;
              end
            end
            default: begin
              state_d = ST_IDLE;
              cnt_d   = 16'd0;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q   <= ST_IDLE;
          cnt_q     <= 16'd0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          level_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
          repeat_q  <= 1'b0;
`endif
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          press_q   <= press_d;
          release_q <= release_d;
          level_q   <= level_d;
`ifdef BTN_AUTO_REPEAT_EN
          repeat_q  <= repeat_d;
`endif
        end
      end

      assign o_level[gi]   = level_q;
      assign o_press[gi]   = press_q;
      assign o_release[gi] = release_q;
`ifdef BTN_AUTO_REPEAT_EN
      assign o_repeat[gi]  = repeat_q;
`else
      assign o_repeat[gi]  = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond: one debounce sample every 4 clocks, outputs checked
// one cycle after each tick edge and again on the following edge (pulse width).
module tb_btn_cond;

  localparam int NB = 3;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic RPT_EN = 1'b1;
`else
  localparam logic RPT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] i_sw = '0;
  logic [NB-1:0] o_level, o_press, o_release, o_repeat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btn_cond #(
    .NUM_BTN (NB),
    .TICK_DIV(4),
    .DEB_MS  (3),
    .HOLD_MS (5),
    .RPT_MS  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sw     (i_sw),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_repeat (o_repeat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called one step after a tick edge; drives one sample and checks the next tick's result.
  task automatic sample(input string tag, input logic [NB-1:0] pr,
                        input logic [NB-1:0] e_press, input logic [NB-1:0] e_rel,
                        input logic [NB-1:0] e_rpt, input logic [NB-1:0] e_lvl);
    logic [NB-1:0] rpt_exp;
    rpt_exp = e_rpt & {NB{RPT_EN}};
    i_sw = ~pr;
    @(posedge clk); #1;
    check($sformatf("%s.gap", tag), {o_press, o_release, o_repeat}, '0);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s.press", tag), o_press, e_press);
    check($sformatf("%s.release", tag), o_release, e_rel);
    check($sformatf("%s.repeat", tag), o_repeat, rpt_exp);
    check($sformatf("%s.level", tag), o_level, e_lvl);
    $display("[TB] %s pr=%b press=%b rel=%b rpt=%b lvl=%b", tag, pr, o_press, o_release,
             o_repeat, o_level);
  endtask

  initial begin
    // Reset with all switches pressed
    rst_n = 1'b0;
    i_sw  = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst.level", o_level, 3'b000);
    check("rst.press", o_press, 3'b000);
    check("rst.release", o_release, 3'b000);
    check("rst.repeat", o_repeat, 3'b000);
    $display("[TB] reset held 3 cycles");

    i_sw  = 3'b111;
    rst_n = 1'b1;
    check("tick.c0", {31'd0, dut.tick}, 0);
    @(posedge clk); #1;
    check("tick.c1", {31'd0, dut.tick}, 0);
    @(posedge clk); #1;
    check("tick.c2", {31'd0, dut.tick}, 0);
    @(posedge clk); #1;
    check("tick.c3", {31'd0, dut.tick}, 1);
    @(posedge clk); #1;
    $display("[TB] first tick after reset release");

    // Glitch on channel 0
    sample("glitch0", 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    sample("glitch1", 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    sample("glitch2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    sample("glitch3", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    // Hold channel 1 for 12 samples
    for (int i = 0; i < 16; i++) begin
      sample($sformatf("hold%0d", i),
             (i < 12) ? 3'b010 : 3'b000,
             (i == 2) ? 3'b010 : 3'b000,
             (i == 14) ? 3'b010 : 3'b000,
             (i == 7 || i == 9 || i == 11) ? 3'b010 : 3'b000,
             (i >= 2 && i <= 13) ? 3'b010 : 3'b000);
    end

    // Release bounce on channel 1
    for (int i = 0; i < 9; i++) begin
      sample($sformatf("bounce%0d", i),
             (i <= 2 || i == 4) ? 3'b010 : 3'b000,
             (i == 2) ? 3'b010 : 3'b000,
             (i == 7) ? 3'b010 : 3'b000,
             3'b000,
             (i >= 2 && i <= 6) ? 3'b010 : 3'b000);
    end

    // Channels 0 and 2 together, into REPEAT
    for (int i = 0; i < 9; i++) begin
      sample($sformatf("sim%0d", i),
             3'b101,
             (i == 2) ? 3'b101 : 3'b000,
             3'b000,
             (i == 7) ? 3'b101 : 3'b000,
             (i >= 2) ? 3'b101 : 3'b000);
    end

    // Reset mid-REPEAT while still held
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst.level", o_level, 3'b000);
    check("midrst.press", o_press, 3'b000);
    check("midrst.release", o_release, 3'b000);
    check("midrst.repeat", o_repeat, 3'b000);
    $display("[TB] reset asserted mid-repeat");
    repeat (2) @(posedge clk);
    #1;
    i_sw  = 3'b111;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample($sformatf("post%0d", i), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
